// File: rtl/debouncer_multi.sv
// Multi-channel pushbutton/switch debouncer: synchroniser, saturating hysteresis
// counter, debounced level, press/release pulses and optional auto-repeat per channel.
module debouncer_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned COUNTER_BITS  = 7,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned HOLD_CYCLES   = 5000000,
    parameter int unsigned REPEAT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] input_unstable,
    output logic [N_CH-1:0] stable_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_press
);

    localparam int unsigned TH    = 2 ** (COUNTER_BITS - 1);
    localparam int unsigned T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [COUNTER_BITS-1:0] C_ZERO  = '0;
    localparam logic [COUNTER_BITS-1:0] C_ONE   = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] C_MAX   = '1;
    localparam logic [COUNTER_BITS-1:0] C_TH_M1 = COUNTER_BITS'(TH - 1);

    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] T_HOLD_M1 = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_REP_M1  = TW'(REPEAT_CYCLES - 1);

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    logic [SYNC_STAGES*N_CH-1:0]     r_sync;
    logic [N_CH-1:0]                 w_s;
    logic [N_CH-1:0][COUNTER_BITS-1:0] r_cnt;
    logic [N_CH-1:0][COUNTER_BITS-1:0] w_cnt_nxt;
    logic [N_CH-1:0][TW-1:0]         r_tmr;
    logic [N_CH-1:0][TW-1:0]         w_tmr_nxt;
    logic [N_CH-1:0]                 r_phase;
    logic [N_CH-1:0]                 w_phase_nxt;
    logic [N_CH-1:0]                 r_level;
    logic [N_CH-1:0]                 w_rise;
    logic [N_CH-1:0]                 w_fall;
    logic [N_CH-1:0]                 w_rep_hit;
    logic [N_CH-1:0]                 r_press;
    logic [N_CH-1:0]                 r_release;
    logic [N_CH-1:0]                 r_repeat;
    logic                            r_any;

    // Stage 0 occupies the low slice; the last stage sits at the top.
    if (SYNC_STAGES > 1) begin : g_sync_multi
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[(SYNC_STAGES-1)*N_CH-1:0], input_unstable};
            end
        end
    end else begin : g_sync_single
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= input_unstable;
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES*N_CH-1 -: N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic w_up;
        logic w_dn;

        assign w_up = w_s[i] && (r_cnt[i] != C_MAX);
        assign w_dn = !w_s[i] && (r_cnt[i] != C_ZERO);
        assign w_cnt_nxt[i] = w_up ? (r_cnt[i] + C_ONE) :
                              w_dn ? (r_cnt[i] - C_ONE) : r_cnt[i];

        assign w_rise[i] = (r_level[i] == ST_LOW)  &&  w_s[i] && (r_cnt[i] == C_TH_M1);
        assign w_fall[i] = (r_level[i] == ST_HIGH) && !w_s[i] && (r_cnt[i] == C_ONE);

        // Phase 0 waits out the initial hold, phase 1 paces the repeats; the
        // timer restarts at every pulse so it never has to count past T_MAX-1.
        assign w_rep_hit[i] = (REPEAT_EN != 0) && (r_level[i] == ST_HIGH) && !w_fall[i] &&
                              (r_phase[i] ? (r_tmr[i] == T_REP_M1) : (r_tmr[i] == T_HOLD_M1));

        assign w_tmr_nxt[i] = (REPEAT_EN == 0 || w_rise[i] || w_fall[i] || w_rep_hit[i]) ? '0 :
                              (r_level[i] == ST_HIGH) ? (r_tmr[i] + T_ONE) : r_tmr[i];

        assign w_phase_nxt[i] = (w_rise[i] || w_fall[i]) ? 1'b0 :
                                w_rep_hit[i] ? 1'b1 : r_phase[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_phase   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_repeat  <= '0;
            r_any     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_tmr     <= w_tmr_nxt;
            r_phase   <= w_phase_nxt;
            r_level   <= (r_level | w_rise) & ~w_fall;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_repeat  <= w_rep_hit;
            r_any     <= |w_rise;
        end
    end

    assign stable_level  = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;
    assign any_press     = r_any;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed self-checking bench for debouncer_multi: one instance without and one
// with auto-repeat, both with 2 channels, 3-bit counters (TH=4, MAX=7), 2 sync stages.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [1:0] in_a = 2'b00;
    logic [1:0] lvl_a, prs_a, rel_a, rep_a;
    logic       any_a;

    logic [1:0] in_b = 2'b00;
    logic [1:0] lvl_b, prs_b, rel_b, rep_b;
    logic       any_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    debouncer_multi #(
        .N_CH(2), .COUNTER_BITS(3), .SYNC_STAGES(2),
        .REPEAT_EN(0), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
    ) u_a (
        .clk(clk), .reset(reset), .input_unstable(in_a),
        .stable_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
        .repeat_pulse(rep_a), .any_press(any_a)
    );

    debouncer_multi #(
        .N_CH(2), .COUNTER_BITS(3), .SYNC_STAGES(2),
        .REPEAT_EN(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
    ) u_b (
        .clk(clk), .reset(reset), .input_unstable(in_b),
        .stable_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
        .repeat_pulse(rep_b), .any_press(any_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({lvl_a, prs_a, rel_a, rep_a, any_a, lvl_b, prs_b, rel_b, rep_b, any_b} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_held: a=%b/%b/%b/%b/%b b=%b/%b/%b/%b/%b, expected all 0",
                     lvl_a, prs_a, rel_a, rep_a, any_a, lvl_b, prs_b, rel_b, rep_b, any_b);
        end
        reset = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            n_tests++;
            if ({lvl_a, prs_a, rel_a, rep_a, any_a, lvl_b, prs_b, rel_b, rep_b, any_b} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_quiet t=%0d: a=%b/%b/%b/%b/%b b=%b/%b/%b/%b/%b, expected all 0", t,
                         lvl_a, prs_a, rel_a, rep_a, any_a, lvl_b, prs_b, rel_b, rep_b, any_b);
            end
        end
    endtask

    // Drive pattern on A for n ticks; press expected at tick 6 on the channels in pat.
    task automatic press_phase_a(input string name, input logic [1:0] pat, input int n);
        logic [1:0] e_prs, e_lvl;
        logic       e_any;
        in_a = pat;
        for (int t = 1; t <= n; t++) begin
            tick();
            e_prs = (t == 6) ? pat : 2'b00;
            e_any = (t == 6);
            e_lvl = (t >= 6) ? pat : 2'b00;
            n_tests++;
            if (prs_a !== e_prs || any_a !== e_any || lvl_a !== e_lvl || rel_a !== 2'b00 || rep_a !== 2'b00) begin
                n_fail++;
                $display("FAIL %s t=%0d: lvl=%b prs=%b any=%b rel=%b rep=%b, expected lvl=%b prs=%b any=%b rel=00 rep=00",
                         name, t, lvl_a, prs_a, any_a, rel_a, rep_a, e_lvl, e_prs, e_any);
            end
        end
    endtask

    // From saturation, release on the channels in pat is expected at tick 9.
    task automatic release_phase_a(input string name, input logic [1:0] pat);
        logic [1:0] e_rel, e_lvl;
        in_a = 2'b00;
        for (int t = 1; t <= 11; t++) begin
            tick();
            e_rel = (t == 9) ? pat : 2'b00;
            e_lvl = (t < 9) ? pat : 2'b00;
            n_tests++;
            if (rel_a !== e_rel || lvl_a !== e_lvl || prs_a !== 2'b00 || any_a !== 1'b0 || rep_a !== 2'b00) begin
                n_fail++;
                $display("FAIL %s t=%0d: lvl=%b rel=%b prs=%b any=%b rep=%b, expected lvl=%b rel=%b prs=00 any=0 rep=00",
                         name, t, lvl_a, rel_a, prs_a, any_a, rep_a, e_lvl, e_rel);
            end
        end
    endtask

    task automatic test_clean_press();
        press_phase_a("clean_press", 2'b01, 12);
        release_phase_a("clean_release", 2'b01);
    endtask

    task automatic test_bounce();
        for (int t = 1; t <= 40; t++) begin
            in_a = (t % 2 == 1) ? 2'b01 : 2'b00;
            tick();
            n_tests++;
            if (lvl_a !== 2'b00 || prs_a !== 2'b00 || rel_a !== 2'b00 || any_a !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce t=%0d: lvl=%b prs=%b rel=%b any=%b, expected all 0",
                         t, lvl_a, prs_a, rel_a, any_a);
            end
        end
        in_a = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_hysteresis();
        press_phase_a("hyst_press", 2'b01, 12);
        for (int t = 1; t <= 17; t++) begin
            in_a = (t <= 5) ? 2'b00 : 2'b01;
            tick();
            n_tests++;
            if (lvl_a !== 2'b01 || prs_a !== 2'b00 || rel_a !== 2'b00 || any_a !== 1'b0) begin
                n_fail++;
                $display("FAIL hysteresis t=%0d: lvl=%b prs=%b rel=%b any=%b, expected lvl=01 prs=00 rel=00 any=0",
                         t, lvl_a, prs_a, rel_a, any_a);
            end
        end
        release_phase_a("hyst_release", 2'b01);
    endtask

    task automatic test_simultaneous();
        press_phase_a("simul_press", 2'b11, 12);
        release_phase_a("simul_release", 2'b11);
    endtask

    // Press edge at tick 6; repeats at 16, 20, 24; the slot at 28 meets the release edge.
    task automatic test_auto_repeat();
        logic [1:0] e_prs, e_rel, e_rep, e_lvl;
        for (int t = 1; t <= 32; t++) begin
            in_b = (t <= 19) ? 2'b01 : 2'b00;
            tick();
            e_prs = (t == 6) ? 2'b01 : 2'b00;
            e_rep = (t == 16 || t == 20 || t == 24) ? 2'b01 : 2'b00;
            e_rel = (t == 28) ? 2'b01 : 2'b00;
            e_lvl = (t >= 6 && t < 28) ? 2'b01 : 2'b00;
            n_tests++;
            if (prs_b !== e_prs || rep_b !== e_rep || rel_b !== e_rel || lvl_b !== e_lvl || any_b !== e_prs[0]) begin
                n_fail++;
                $display("FAIL auto_repeat t=%0d: lvl=%b prs=%b rep=%b rel=%b any=%b, expected lvl=%b prs=%b rep=%b rel=%b any=%b",
                         t, lvl_b, prs_b, rep_b, rel_b, any_b, e_lvl, e_prs, e_rep, e_rel, e_prs[0]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        in_a = 2'b01;
        in_b = 2'b01;
        repeat (6) tick();
        n_tests++;
        if (prs_a !== 2'b01 || lvl_a !== 2'b01 || prs_b !== 2'b01 || lvl_b !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset_press: a lvl=%b prs=%b b lvl=%b prs=%b, expected 01 for all",
                     lvl_a, prs_a, lvl_b, prs_b);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({lvl_a, prs_a, rel_a, rep_a, any_a, lvl_b, prs_b, rel_b, rep_b, any_b} !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset: a=%b/%b/%b/%b/%b b=%b/%b/%b/%b/%b, expected all 0",
                     lvl_a, prs_a, rel_a, rep_a, any_a, lvl_b, prs_b, rel_b, rep_b, any_b);
        end
        #2 reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_tests++;
            if (prs_a !== ((t == 6) ? 2'b01 : 2'b00) || lvl_a !== ((t >= 6) ? 2'b01 : 2'b00) ||
                prs_b !== ((t == 6) ? 2'b01 : 2'b00) || any_a !== (t == 6)) begin
                n_fail++;
                $display("FAIL repress_after_reset t=%0d: a lvl=%b prs=%b any=%b b prs=%b, expected press at t=6 only",
                         t, lvl_a, prs_a, any_a, prs_b);
            end
        end
        in_a = 2'b00;
        in_b = 2'b00;
        repeat (14) tick();
        n_tests++;
        if (lvl_a !== 2'b00 || lvl_b !== 2'b00) begin
            n_fail++;
            $display("FAIL final_release: lvl_a=%b lvl_b=%b, expected 00 00", lvl_a, lvl_b);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hysteresis();
        test_simultaneous();
        test_auto_repeat();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
